// File: rtl/data_sram_resp.sv
// Data-SRAM responder: single-port word RAM with a READ_LAT-deep read pipeline,
// illegal-address flagging and saturating read/write statistics.
module data_sram_resp #(
   parameter int ADDR_W   = 7,
   parameter int READ_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_sram_en,
   input  logic             data_sram_wen,
   input  logic [31:0]      data_sram_addr,
   input  logic [31:0]      data_sram_wdata,
   output logic [31:0]      data_sram_rdata,
   output logic             rvalid,
   output logic             addr_err,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0]         mem [DEPTH];
   logic [ADDR_W-1:0]   idx;
   logic                legal;
   logic                rd_req;
   logic                rd_ok;
   logic                wr_ok;

   // Index 0 is stage 1; the last stage drives the outputs directly.
   logic [31:0]         stg_data_q [READ_LAT];
   logic [31:0]         stg_data_d [READ_LAT];
   logic [READ_LAT-1:0] stg_vld_q;
   logic [READ_LAT-1:0] stg_vld_d;
   logic                addr_err_q, addr_err_d;
   logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
      return v;
   endfunction

   always_comb begin
      idx    = data_sram_addr[ADDR_W+1:2];
      legal  = (data_sram_addr[1:0] == 2'b00) && (data_sram_addr[31:ADDR_W+2] == '0);
      rd_req = data_sram_en && !data_sram_wen;
      rd_ok  = rd_req && legal;
      wr_ok  = data_sram_en && data_sram_wen && legal;
   end

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[idx] <= data_sram_wdata;
   end

   always_comb begin
      stg_vld_d     = stg_vld_q;
      stg_data_d    = stg_data_q;
      stg_vld_d[0]  = rd_req;
      // The array is sampled at issue, so a write in the next cycle cannot disturb this read.
      if (rd_req) stg_data_d[0] = legal ? mem[idx] : 32'h0;
      for (int k = 1; k < READ_LAT; k++) begin
         stg_vld_d[k] = stg_vld_q[k-1];
         if (stg_vld_q[k-1]) stg_data_d[k] = stg_data_q[k-1];
      end
      addr_err_d = data_sram_en && !legal;
      rd_cnt_d   = sat_inc(rd_cnt_q, rd_ok);
      wr_cnt_d   = sat_inc(wr_cnt_q, wr_ok);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_vld_q  <= '0;
         for (int k = 0; k < READ_LAT; k++) stg_data_q[k] <= 32'h0;
         addr_err_q <= 1'b0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
      end else begin
         stg_vld_q  <= stg_vld_d;
         for (int k = 0; k < READ_LAT; k++) stg_data_q[k] <= stg_data_d[k];
         addr_err_q <= addr_err_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   assign data_sram_rdata = stg_data_q[READ_LAT-1];
   assign rvalid          = stg_vld_q[READ_LAT-1];
   assign addr_err        = addr_err_q;
   assign rd_cnt          = rd_cnt_q;
   assign wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: directed vector table, multi-cycle corner sequences
// and randomized traffic against a per-request reference model.
module tb_data_sram_resp;

   localparam int ADDR_W = 7;
   localparam int LAT    = 3;
   localparam int CNT_W  = 8;
   localparam int NV     = 14;

   logic             clk;
   logic             rst;
   logic             en;
   logic             wen;
   logic [31:0]      addr;
   logic [31:0]      wdata;
   logic [31:0]      rdata;
   logic             rvalid;
   logic             addr_err;
   logic [CNT_W-1:0] rd_cnt;
   logic [CNT_W-1:0] wr_cnt;

   data_sram_resp #(.ADDR_W(ADDR_W), .READ_LAT(LAT), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .rvalid          (rvalid),
      .addr_err        (addr_err),
      .rd_cnt          (rd_cnt),
      .wr_cnt          (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        vld;
      logic [31:0] data;
      logic        hchk;
      logic [31:0] hdata;
   } ent_t;

   typedef struct {
      logic        en;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic        hchk;
      logic [31:0] hdata;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mm [2**ADDR_W];
   ent_t        hist [$];
   logic [31:0] m_last;
   int          m_rd, m_wr;
   logic        m_err;
   vec_t        tv [NV];

   function automatic logic [31:0] pre(input int i);
      return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      ent_t b;
      b = '0;
      hist.delete();
      for (int i = 0; i < LAT - 1; i++) hist.push_back(b);
      m_last = 32'h0;
      m_rd   = 0;
      m_wr   = 0;
      m_err  = 1'b0;
   endtask

   task automatic do_reset();
      en  = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
      chk("rst_rd_cnt", 32'(rd_cnt), 32'h0);
      chk("rst_wr_cnt", 32'(wr_cnt), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // One request per clock; the model decides each request's fate from the
   // address rules and retires results strictly LAT edges later.
   task automatic step(input logic e, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic hc = 1'b0, input logic [31:0] hd = 32'h0);
      ent_t ent, front;
      logic lg;
      int   wi;
      en = e; wen = w; addr = a; wdata = d;
      @(posedge clk);
      lg  = (a[1:0] == 2'b00) && (a[31:ADDR_W+2] == '0);
      wi  = int'(a[ADDR_W+1:2]);
      ent = '0;
      if (e && !w) begin
         ent.vld   = 1'b1;
         ent.data  = lg ? mm[wi] : 32'h0;
         ent.hchk  = hc;
         ent.hdata = hd;
         if (lg && m_rd < 2**CNT_W - 1) m_rd++;
      end
      if (e && w && lg) begin
         mm[wi] = d;
         if (m_wr < 2**CNT_W - 1) m_wr++;
      end
      m_err = e && !lg;
      hist.push_back(ent);
      front = hist.pop_front();
      if (front.vld) m_last = front.data;
      #1;
      chk("rvalid", {31'h0, rvalid}, {31'h0, front.vld});
      chk("rdata", rdata, m_last);
      chk("addr_err", {31'h0, addr_err}, {31'h0, m_err});
      chk("rd_cnt", 32'(rd_cnt), 32'(m_rd));
      chk("wr_cnt", 32'(wr_cnt), 32'(m_wr));
      if (front.hchk) begin
         chk("hand_rvalid", {31'h0, rvalid}, 32'h1);
         chk("hand_rdata", rdata, front.hdata);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; wen = 1'b0; addr = 32'h0; wdata = 32'h0;
      model_reset();
      #2;
      do_reset();

      // Give every word a known value, then clear the statistics.
      for (int i = 0; i < 2**ADDR_W; i++) step(1'b1, 1'b1, 32'(i) << 2, pre(i));
      do_reset();

      tv[0]  = '{1'b1, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
      tv[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
      tv[2]  = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, pre(0)};
      tv[3]  = '{1'b1, 1'b0, 32'h4,   32'h0,        1'b0, 1'b1, pre(1)};
      tv[4]  = '{1'b1, 1'b0, 32'h8,   32'h0,        1'b0, 1'b1, pre(2)};
      tv[5]  = '{1'b1, 1'b1, 32'h20,  32'h5,        1'b0, 1'b0, 32'h0};
      tv[6]  = '{1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 1'b1, 32'h5};
      tv[7]  = '{1'b1, 1'b1, 32'h20,  32'h1,        1'b0, 1'b0, 32'h0};
      tv[8]  = '{1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 1'b1, 32'h1};
      tv[9]  = '{1'b1, 1'b0, 32'h202, 32'h0,        1'b1, 1'b1, 32'h0};
      tv[10] = '{1'b1, 1'b1, 32'h400, 32'hFFFF0000, 1'b1, 1'b0, 32'h0};
      tv[11] = '{1'b0, 1'b1, 32'h20,  32'hBAD0BAD0, 1'b0, 1'b0, 32'h0};
      tv[12] = '{1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 1'b1, 32'h1};
      tv[13] = '{1'b1, 1'b0, 32'h400, 32'h0,        1'b1, 1'b1, 32'h0};
      for (int i = 0; i < NV; i++) begin
         step(tv[i].en, tv[i].wen, tv[i].addr, tv[i].wdata, tv[i].hchk, tv[i].hdata);
         chk("tab_addr_err", {31'h0, addr_err}, {31'h0, tv[i].exp_err});
      end
      idle(LAT + 1);
      chk("tab_wr_total", 32'(wr_cnt), 32'd3);
      chk("tab_rd_total", 32'(rd_cnt), 32'd7);
      chk("tab_rdata_hold", rdata, 32'h0);

      // Reset with results in flight and one already on the outputs.
      step(1'b1, 1'b0, 32'h4, 32'h0);
      step(1'b1, 1'b0, 32'h8, 32'h0);
      step(1'b1, 1'b0, 32'hC, 32'h0);
      step(1'b1, 1'b0, 32'h10, 32'h0);
      do_reset();
      for (int i = 0; i < 2 * LAT; i++) begin
         step(1'b0, 1'b0, 32'h0, 32'h0);
         chk("post_rst_rvalid", {31'h0, rvalid}, 32'h0);
      end
      step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
      step(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h1);
      idle(LAT);

      // Saturation of both counters.
      for (int i = 0; i < 2**CNT_W + 4; i++)
         step(1'b1, 1'b1, 32'($urandom_range(0, 2**ADDR_W - 1)) << 2, $urandom);
      chk("wr_cnt_sat", 32'(wr_cnt), 32'(2**CNT_W - 1));
      for (int i = 0; i < 2**CNT_W + 4; i++)
         step(1'b1, 1'b0, 32'($urandom_range(0, 2**ADDR_W - 1)) << 2, 32'h0);
      idle(LAT);
      chk("rd_cnt_sat", 32'(rd_cnt), 32'(2**CNT_W - 1));

      do_reset();
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] a;
         if (i == 750) do_reset();
         a = ($urandom_range(0, 9) < 8) ? (32'($urandom_range(0, 2**ADDR_W - 1)) << 2) : $urandom;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom);
      end
      idle(LAT);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
